// File: rtl/quickq_sort_router.sv
// Sequential compare-and-route engine for the QuickQ priority queue.
// Keeps a sorted array in an external 1-cycle-latency single-port BRAM.
module quickq_sort_router #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1),
  parameter int unsigned MAX_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_rd_en,
  input  logic [DATA_W-1:0] bram_rd_data,
  output logic              bram_wr_en,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam logic [1:0] OpInsert = 2'b01;
  localparam logic [1:0] OpRemove = 2'b10;
  localparam logic [1:0] OpPeek   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCmp,
    StFill,
    StShiftRd,
    StShiftWr,
    StDone
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] carry_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  count_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              cmp_beats;
  logic              is_full;
  logic              is_empty;

  // Strict ordering so equal keys never displace earlier arrivals.
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MAX_FIRST != 0) begin
      return a > b;
    end
    return a < b;
  endfunction

  assign cmp_beats = beats(carry_q, bram_rd_data);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign is_empty  = (count_q == '0);

  assign op_ready  = (state_q == StIdle);
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

  // BRAM strobes are decoded from state; the CMP write depends on data returned that cycle.
  always_comb begin
    bram_addr    = '0;
    bram_rd_en   = 1'b0;
    bram_wr_en   = 1'b0;
    bram_wr_data = '0;
    case (state_q)
      StRd: begin
        bram_addr  = idx_q[ADDR_W-1:0];
        bram_rd_en = 1'b1;
      end
      StCmp: begin
        bram_addr = idx_q[ADDR_W-1:0];
        if (op_q == OpInsert && cmp_beats) begin
          bram_wr_en   = 1'b1;
          bram_wr_data = carry_q;
        end
      end
      StFill: begin
        bram_addr    = n_q[ADDR_W-1:0];
        bram_wr_en   = 1'b1;
        bram_wr_data = carry_q;
      end
      StShiftRd: begin
        bram_addr  = idx_q[ADDR_W-1:0] + ADDR_W'(1);
        bram_rd_en = 1'b1;
      end
      StShiftWr: begin
        bram_addr    = idx_q[ADDR_W-1:0];
        bram_wr_en   = 1'b1;
        bram_wr_data = bram_rd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      carry_q     <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (op_valid) begin
            op_q    <= op_code;
            carry_q <= op_data;
            idx_q   <= '0;
            n_q     <= count_q;
            if ((op_code == OpInsert && is_full) ||
                ((op_code == OpRemove || op_code == OpPeek) && is_empty) ||
                (op_code == 2'b00)) begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else if (op_code == OpInsert && is_empty) begin
              state_q <= StFill;
            end else begin
              state_q <= StRd;
            end
          end
        end

        StRd: state_q <= StCmp;

        StCmp: begin
          unique case (op_q)
            OpInsert: begin
              if (cmp_beats) begin
                carry_q <= bram_rd_data;
              end
              if (idx_q == n_q - CNT_W'(1)) begin
                state_q <= StFill;
              end else begin
                idx_q   <= idx_q + CNT_W'(1);
                state_q <= StRd;
              end
            end
            OpRemove: begin
              carry_q <= bram_rd_data;
              if (n_q == CNT_W'(1)) begin
                state_q     <= StDone;
                count_q     <= '0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bram_rd_data;
              end else begin
                idx_q   <= '0;
                state_q <= StShiftRd;
              end
            end
            default: begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= bram_rd_data;
            end
          endcase
        end

        StFill: begin
          state_q     <= StDone;
          count_q     <= n_q + CNT_W'(1);
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
        end

        StShiftRd: state_q <= StShiftWr;

        StShiftWr: begin
          if (idx_q == n_q - CNT_W'(2)) begin
            state_q     <= StDone;
            count_q     <= n_q - CNT_W'(1);
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= carry_q;
          end else begin
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= StShiftRd;
          end
        end

        StDone: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_sort_router.sv
// Bench for quickq_sort_router: two DEPTH=4 instances (min-first, max-first),
// BRAM models, directed steps and randomized ops against a sorted-queue reference.
module tb_quickq_sort_router;

  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 4;
  localparam logic [1:0] OpIns = 2'b01;
  localparam logic [1:0] OpRem = 2'b10;
  localparam logic [1:0] OpPk  = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid[2];
  logic             op_ready[2];
  logic [1:0]       op_code[2];
  logic [DataW-1:0] op_data[2];
  logic [1:0]       bram_addr[2];
  logic             bram_rd_en[2];
  logic [DataW-1:0] bram_rd_data[2];
  logic             bram_wr_en[2];
  logic [DataW-1:0] bram_wr_data[2];
  logic             rsp_valid[2];
  logic [DataW-1:0] rsp_data[2];
  logic             rsp_err[2];
  logic [2:0]       count[2];
  logic             full[2];
  logic             empty[2];

  logic [DataW-1:0] mem0[Depth];
  logic [DataW-1:0] mem1[Depth];

  int tests = 0;
  int fails = 0;
  int overlap = 0;
  int idle_addr_bad = 0;

  logic [DataW-1:0] mq0[$];
  logic [DataW-1:0] mq1[$];

  always #5 clk = ~clk;

  quickq_sort_router #(.DATA_W(DataW), .DEPTH(Depth), .MAX_FIRST(0)) u_min (
    .clk(clk), .rst(rst), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .op_code(op_code[0]), .op_data(op_data[0]), .bram_addr(bram_addr[0]),
    .bram_rd_en(bram_rd_en[0]), .bram_rd_data(bram_rd_data[0]), .bram_wr_en(bram_wr_en[0]),
    .bram_wr_data(bram_wr_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .count(count[0]), .full(full[0]), .empty(empty[0])
  );

  quickq_sort_router #(.DATA_W(DataW), .DEPTH(Depth), .MAX_FIRST(1)) u_max (
    .clk(clk), .rst(rst), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .op_code(op_code[1]), .op_data(op_data[1]), .bram_addr(bram_addr[1]),
    .bram_rd_en(bram_rd_en[1]), .bram_rd_data(bram_rd_data[1]), .bram_wr_en(bram_wr_en[1]),
    .bram_wr_data(bram_wr_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .count(count[1]), .full(full[1]), .empty(empty[1])
  );

  always @(posedge clk) begin
    if (bram_wr_en[0] === 1'b1) mem0[bram_addr[0]] <= bram_wr_data[0];
    if (bram_rd_en[0] === 1'b1) bram_rd_data[0] <= mem0[bram_addr[0]];
    if (bram_wr_en[1] === 1'b1) mem1[bram_addr[1]] <= bram_wr_data[1];
    if (bram_rd_en[1] === 1'b1) bram_rd_data[1] <= mem1[bram_addr[1]];
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (bram_rd_en[u] === 1'b1 && bram_wr_en[u] === 1'b1) overlap++;
      if (!rst && op_ready[u] === 1'b1 && bram_addr[u] !== 2'd0) idle_addr_bad++;
    end
  end

  task automatic check(input string tag, input logic [DataW-1:0] obs,
                       input logic [DataW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait (bounded) for its response; leaves the DUT back in idle.
  task automatic do_op(input int u, input logic [1:0] code, input logic [DataW-1:0] data,
                       output int lat, output logic [DataW-1:0] rdata, output logic rerr,
                       output int wr_seen);
    check("op_ready_before_op", {31'd0, op_ready[u]}, 32'd1);
    op_valid[u] = 1'b1;
    op_code[u]  = code;
    op_data[u]  = data;
    @(posedge clk); #1;
    op_valid[u] = 1'b0;
    op_code[u]  = 2'(1 + $urandom_range(0, 2));
    op_data[u]  = $urandom;
    lat = 0;
    rdata = '0;
    rerr = 1'b0;
    wr_seen = 0;
    for (int c = 1; c <= 64; c++) begin
      if (bram_wr_en[u] === 1'b1) wr_seen++;
      if (rsp_valid[u] === 1'b1) begin
        lat = c;
        rdata = rsp_data[u];
        rerr = rsp_err[u];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Reference: ordered queue, insert before the first element the new value beats.
  task automatic model_op(input int u, input logic [1:0] code, input logic [DataW-1:0] v,
                          output int lat, output logic [DataW-1:0] d, output logic e);
    logic [DataW-1:0] q[$];
    int n;
    int pos;
    q = (u == 0) ? mq0 : mq1;
    n = q.size();
    d = '0;
    e = 1'b0;
    if (code == 2'b00 || (code == OpIns && n == Depth) || (code != OpIns && n == 0)) begin
      e = 1'b1;
      lat = 1;
    end else if (code == OpIns) begin
      pos = n;
      for (int i = n - 1; i >= 0; i--) begin
        if ((u == 0) ? (v < q[i]) : (v > q[i])) pos = i;
      end
      q.insert(pos, v);
      lat = 2 * n + 2;
    end else if (code == OpRem) begin
      d = q.pop_front();
      lat = 2 * n + 1;
    end else begin
      d = q[0];
      lat = 3;
    end
    if (u == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic run_random(input int u, input int nops);
    logic [1:0] code;
    logic [DataW-1:0] v;
    int r, lat, elat, wr;
    logic [DataW-1:0] d, ed;
    logic e, ee;
    for (int k = 0; k < nops; k++) begin
      r = $urandom_range(0, 9);
      code = (r == 0) ? 2'b00 : (r <= 4) ? OpIns : (r <= 7) ? OpRem : OpPk;
      v = (u == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      model_op(u, code, v, elat, ed, ee);
      do_op(u, code, v, lat, d, e, wr);
      check("rand_latency", 32'(lat), 32'(elat));
      check("rand_err", {31'd0, e}, {31'd0, ee});
      check("rand_data", d, ed);
      check("rand_count", {29'd0, count[u]}, 32'((u == 0) ? mq0.size() : mq1.size()));
    end
  endtask

  initial begin
    int lat, wr, strobes;
    logic [DataW-1:0] d;
    logic e;
    logic [DataW-1:0] ins_vals[4];
    logic [DataW-1:0] rem_vals[4];
    ins_vals = '{32'd5, 32'd2, 32'd9, 32'd2};
    rem_vals = '{32'd2, 32'd2, 32'd5, 32'd9};
    for (int u = 0; u < 2; u++) begin
      op_valid[u] = 1'b0;
      op_code[u]  = 2'b00;
      op_data[u]  = '0;
    end

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", {29'd0, count[0]}, 32'd0);
    check("reset_empty", {31'd0, empty[0]}, 32'd1);
    check("reset_full", {31'd0, full[0]}, 32'd0);
    check("reset_op_ready", {31'd0, op_ready[0]}, 32'd1);
    check("reset_strobes", {30'd0, bram_rd_en[0], bram_wr_en[0]}, 32'd0);
    check("reset_rsp", {30'd0, rsp_valid[0], rsp_err[0]}, 32'd0);
    check("reset_addr_wdata", {30'd0, bram_addr[0]} | bram_wr_data[0] | rsp_data[0], 32'd0);

    // Fill min-first queue: 5, 2, 9, 2.
    for (int i = 0; i < 4; i++) begin
      do_op(0, OpIns, ins_vals[i], lat, d, e, wr);
      check("insert_latency", 32'(lat), 32'(2 * i + 2));
      check("insert_err", {31'd0, e}, 32'd0);
    end
    check("filled_count", {29'd0, count[0]}, 32'd4);
    check("filled_full", {31'd0, full[0]}, 32'd1);
    for (int i = 0; i < 4; i++) check("slot_contents", mem0[i], rem_vals[i]);

    do_op(0, OpIns, 32'd7, lat, d, e, wr);
    check("full_reject_latency", 32'(lat), 32'd1);
    check("full_reject_err", {31'd0, e}, 32'd1);
    check("full_reject_no_write", 32'(wr), 32'd0);
    check("full_reject_count", {29'd0, count[0]}, 32'd4);

    for (int i = 0; i < 4; i++) begin
      do_op(0, OpRem, '0, lat, d, e, wr);
      check("remove_data", d, rem_vals[i]);
      check("remove_latency", 32'(lat), 32'(2 * (4 - i) + 1));
      check("remove_err", {31'd0, e}, 32'd0);
    end
    check("drained_empty", {31'd0, empty[0]}, 32'd1);
    do_op(0, OpRem, '0, lat, d, e, wr);
    check("empty_remove_err", {31'd0, e}, 32'd1);
    check("empty_remove_data", d, 32'd0);
    check("empty_remove_latency", 32'(lat), 32'd1);

    run_random(0, 60);

    // Reset during cycle 3 of an insert with three elements stored.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 3; i++) do_op(0, OpIns, 32'(10 + i), lat, d, e, wr);
    check("pre_abort_count", {29'd0, count[0]}, 32'd3);
    op_valid[0] = 1'b1;
    op_code[0]  = OpIns;
    op_data[0]  = 32'd4;
    @(posedge clk); #1;
    op_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      if (bram_rd_en[0] !== 1'b0 || bram_wr_en[0] !== 1'b0 || rsp_valid[0] !== 1'b0) strobes++;
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
    check("abort_no_activity", 32'(strobes), 32'd0);
    check("abort_count", {29'd0, count[0]}, 32'd0);
    check("abort_op_ready", {31'd0, op_ready[0]}, 32'd1);
    do_op(0, OpPk, '0, lat, d, e, wr);
    check("abort_peek_err", {31'd0, e}, 32'd1);

    // Max-first ordering with unsigned compare.
    do_op(1, OpIns, 32'hf657c062, lat, d, e, wr);
    do_op(1, OpIns, 32'hf680d628, lat, d, e, wr);
    do_op(1, OpIns, 32'd1, lat, d, e, wr);
    do_op(1, OpPk, '0, lat, d, e, wr);
    check("max_peek_data", d, 32'hf680d628);
    check("max_peek_latency", 32'(lat), 32'd3);
    check("max_count", {29'd0, count[1]}, 32'd3);
    mq1 = '{32'hf680d628, 32'hf657c062, 32'd1};
    run_random(1, 40);

    check("rd_wr_overlap", 32'(overlap), 32'd0);
    check("idle_addr_nonzero", 32'(idle_addr_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quickq_sort_router.md
# quickq_sort_router

Parametrised, sequential compare-and-route engine for the QuickQ priority queue. Owns a DEPTH-slot sorted array held in an external single-port BRAM (1-cycle read latency), walks it with a compare/swap carry register on insert, shifts it on remove, and tracks element count with full/empty flags. It sits between the queue command interface and the slot BRAM, replacing the per-step combinational router with a self-sequenced, handshaked block.

## Interface
- DATA_W, 32, element width; comparison is unsigned.
- DEPTH, 8, queue capacity in slots (≥2).
- ADDR_W, $clog2(DEPTH), BRAM address width.
- CNT_W, $clog2(DEPTH+1), count width.
- MAX_FIRST, 0, ordering: 0 = smallest at slot 0; 1 = largest at slot 0.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  command valid.
- op_ready  out  1  command accepted when op_valid & op_ready.
- op_code  in  2  01 INSERT, 10 REMOVE, 11 PEEK, 00 reserved.
- op_data  in  DATA_W  value to insert; captured at accept.
- bram_addr  out  ADDR_W  slot address (shared read/write).
- bram_rd_en  out  1  read strobe; data valid next cycle.
- bram_rd_data  in  DATA_W  slot read data.
- bram_wr_en  out  1  write strobe.
- bram_wr_data  out  DATA_W  slot write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  head value for REMOVE/PEEK; 0 otherwise or on error.
- rsp_err  out  1  qualifies rsp_valid: op rejected.
- count  out  CNT_W  elements stored.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- "Beats(a,b)": MAX_FIRST=0 → a < b; MAX_FIRST=1 → a > b; strict, so equal keys keep arrival order.
- States: IDLE, RD, CMP, FILL, SHIFT_RD, SHIFT_WR, DONE. op_ready = (state == IDLE).
- Accept in IDLE: latch op_code, op_data→carry, idx=0, n=count.
- Error check at accept: INSERT & full, REMOVE/PEEK & empty, or op_code 00 → DONE with rsp_err=1, no BRAM access, count unchanged.
- INSERT: for idx 0..n-1: RD (rd_en, addr=idx) → CMP: if Beats(carry, rd_data) write carry to idx, carry←rd_data; else no write. After last slot (or immediately if n=0): FILL writes carry to addr n → DONE; count←n+1.
- REMOVE: RD(0) → CMP captures rd_data into rsp_data, no write; then for i 0..n-2: SHIFT_RD (addr=i+1) → SHIFT_WR (addr=i, data=rd_data) → DONE; count←n-1. Slot n-1 is left stale and ignored.
- PEEK: RD(0) → CMP captures rsp_data → DONE; no write, count unchanged.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- bram_rd_en and bram_wr_en are never high in the same cycle; bram_addr is 0 when idle.
- op_valid while busy is not accepted; op_data changes after accept are ignored.

## Timing
- Reset values: op_ready 1 (from first post-reset cycle), state IDLE, count 0, empty 1, full 0, rsp_valid 0, rsp_err 0, rsp_data 0, bram_rd_en 0, bram_wr_en 0, bram_addr 0, bram_wr_data 0.
- Cycle 1 = first cycle after the accept edge.
- INSERT, count n: RD/CMP pairs cycles 1..2n, FILL cycle 2n+1, rsp_valid cycle 2n+2.
- REMOVE, count n: head RD/CMP cycles 1–2, shift cycles 3..2n, rsp_valid cycle 2n+1.
- PEEK: rsp_valid cycle 3. Error: rsp_valid cycle 1.
- count/full/empty update on the edge entering DONE; new values visible during the rsp_valid cycle.
- Next command can be accepted the cycle after DONE.
- Reset mid-operation: the operation is abandoned, no further BRAM strobes after the reset edge, count→0 (queue logically cleared), op_ready 1 next cycle, no rsp_valid for the aborted op.

## Test plan
- Reset: assert rst 2 cycles → count 0, empty 1, full 0, op_ready 1, all strobes 0.
- DEPTH=4, MAX_FIRST=0: INSERT 5, 2, 9, 2 → slots [2,2,5,9], count 4, full 1; the 4th insert (n=3) rsp_valid at cycle 8.
- Full rejection: INSERT 7 when full → rsp_valid+rsp_err at cycle 1, no bram_wr_en, count stays 4.
- Drain: 4× REMOVE → rsp_data 2, 2, 5, 9, the first at cycle 9; empty 1 after the last. 5th REMOVE → rsp_err 1, rsp_data 0.
- MAX_FIRST=1: INSERT 32'hf657c062, 32'hf680d628, 32'd1; PEEK → rsp_data 32'hf680d628 at cycle 3 (unsigned compare), count 3.
- Reset during INSERT cycle 3 (n=3) → no strobes afterward, count 0, op_ready 1, no rsp_valid; subsequent PEEK → rsp_err.
